// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and receiver state encoding for the UART.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_OS        = 16;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_BAUD_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Reloadable down-counter giving one tick every baud_div+1 clks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic [UART_BAUD_W-1:0] baud_div,
    output logic                   tick
);

    logic [UART_BAUD_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= baud_div;
        end else if (en) begin
            r_cnt <= (r_cnt == '0) ? baud_div : r_cnt - 1'b1;
        end
    end

    assign tick = en && !clr && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, 16x oversampled, with framing-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int OS          = UART_OS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [UART_BAUD_W-1:0] baud_div,
    input  logic                   rx,
    output logic [7:0]             data,
    output logic                   done,
    output logic                   frame_err
);

    localparam int c_tick_w = $clog2(OS);
    localparam int c_bit_w  = $clog2(UART_DATA_BITS);
    localparam logic [c_tick_w-1:0] c_mid_tick  = c_tick_w'(OS / 2 - 1);
    localparam logic [c_tick_w-1:0] c_last_tick = c_tick_w'(OS - 1);
    localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(UART_DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;

    rx_state_t              r_state, w_state_nxt;
    logic [c_tick_w-1:0]    r_tick_cnt, w_tick_nxt;
    logic [c_bit_w-1:0]     r_bit_cnt, w_bit_nxt;
    logic [7:0]             r_shift, w_shift_nxt;
    logic [7:0]             r_data, w_data_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_ferr, w_ferr_nxt;
    logic                   r_armed, w_armed_nxt;
    logic                   w_clr;
    logic                   w_tick;

    // Synchronizer resets to ones so the line looks idle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    uart_baud_tick u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en && (r_state != IDLE)),
        .clr      (w_clr),
        .baud_div (baud_div),
        .tick     (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_armed    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_data     <= w_data_nxt;
            r_done     <= w_done_nxt;
            r_ferr     <= w_ferr_nxt;
            r_armed    <= w_armed_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_ferr_nxt  = r_ferr;
        w_done_nxt  = 1'b0;
        w_armed_nxt = r_armed | w_rxs;
        w_clr       = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_armed && !w_rxs) begin
                        w_state_nxt = START;
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_clr       = 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_mid_tick) begin
                            // Restarting here puts every later sample mid-bit.
                            w_tick_nxt  = '0;
                            w_state_nxt = w_rxs ? IDLE : DATA;
                        end else begin
                            w_tick_nxt = r_tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_last_tick) begin
                            w_tick_nxt  = '0;
                            w_shift_nxt = {w_rxs, r_shift[7:1]};
                            w_bit_nxt   = r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_last_bit) begin
                                w_state_nxt = STOP;
                            end
                        end else begin
                            w_tick_nxt = r_tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_last_tick) begin
                            w_data_nxt  = r_shift;
                            w_ferr_nxt  = !w_rxs;
                            w_done_nxt  = 1'b1;
                            // A low stop bit (e.g. break) must see the line high before re-arming.
                            w_armed_nxt = w_rxs;
                            w_tick_nxt  = '0;
                            w_state_nxt = IDLE;
                        end else begin
                            w_tick_nxt = r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign data      = r_data;
    assign done      = r_done;
    assign frame_err = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Scoreboard bench for uart_rx driving 8N1 frames on rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int c_bd  = 9;
    localparam int c_bit = (c_bd + 1) * UART_OS;
    localparam int c_lat = 19 * c_bit / 2 + 2 + 1;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        en       = 1'b0;
    logic [15:0] baud_div = 16'(c_bd);
    logic        rx       = 1'b1;
    logic [7:0]  data;
    logic        done;
    logic        frame_err;

    uart_rx #(.OS(UART_OS), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .baud_div  (baud_div),
        .rx        (rx),
        .data      (data),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard entries are {frame_err, data}.
    logic [8:0] sb_q[$];
    logic [8:0] m_exp;
    int done_cnt      = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    int start_cyc     = 0;

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                m_exp = sb_q.pop_front();
                check("data", 32'(data), 32'(m_exp[7:0]));
                check("frame_err", 32'(frame_err), 32'(m_exp[8]));
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        rx = 1'b0;
        clks(c_bit);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            clks(c_bit);
        end
        rx = stop_bit;
        clks(c_bit);
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        sb_q.push_back({~stop_bit, b});
        drive_frame(b, stop_bit);
    endtask

    task automatic wait_sb(input int max);
        int n = 0;
        while (sb_q.size() != 0 && n < max) begin
            clks(1);
            n++;
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    int d0;
    int gap;

    initial begin
        #2 rst_n = 1'b0;
        #2;
        check("rst_data", 32'(data), 32'h00);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        clks(3);
        rst_n = 1'b1;
        en    = 1'b1;
        clks(20);

        // Single frame with latency
        d0 = done_cnt;
        send(8'hA5, 1'b1);
        wait_sb(4 * c_bit);
        check("a5_done_count", 32'(done_cnt - d0), 32'd1);
        check("a5_latency", 32'(last_done_cyc - start_cyc), 32'(c_lat));
        clks(c_bit);

        // Back-to-back frames
        d0 = done_cnt;
        send(8'hA5, 1'b1);
        send(8'hF0, 1'b1);
        wait_sb(4 * c_bit);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        gap = last_done_cyc - prev_done_cyc;
        check("b2b_spacing", 32'(gap), 32'(10 * c_bit));
        clks(c_bit);

        // Glitch shorter than half a bit
        d0 = done_cnt;
        rx = 1'b0;
        clks(40);
        rx = 1'b1;
        clks(60);
        check("glitch_idle", 32'(dut.r_state), 32'(IDLE));
        clks(2 * c_bit);
        check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
        send(8'h3C, 1'b1);
        wait_sb(4 * c_bit);
        clks(c_bit);

        // Framing error then a good frame
        send(8'h55, 1'b0);
        wait_sb(4 * c_bit);
        clks(c_bit);
        send(8'h01, 1'b1);
        wait_sb(4 * c_bit);
        clks(c_bit);

        // Break: one errored frame of zeros, nothing more while low
        d0 = done_cnt;
        sb_q.push_back({1'b1, 8'h00});
        rx = 1'b0;
        clks(30 * c_bit);
        check("break_done_count", 32'(done_cnt - d0), 32'd1);
        rx = 1'b1;
        clks(2 * c_bit);
        check("break_no_more", 32'(done_cnt - d0), 32'd1);
        wait_sb(4 * c_bit);
        send(8'h81, 1'b1);
        wait_sb(4 * c_bit);
        clks(c_bit);

        // Abort by en=0 in bit 4
        d0 = done_cnt;
        fork
            drive_frame(8'h96, 1'b1);
            begin
                clks(5 * c_bit + c_bit / 2);
                en = 1'b0;
            end
        join
        clks(c_bit);
        en = 1'b1;
        clks(c_bit);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_data_kept", 32'(data), 32'h81);
        check("abort_ferr_kept", 32'(frame_err), 32'd0);

        // Async reset in bit 6
        fork
            drive_frame(8'h5A, 1'b1);
            begin
                clks(7 * c_bit + c_bit / 2);
                #2 rst_n = 1'b0;
                #1;
                check("mid_rst_data", 32'(data), 32'h00);
                check("mid_rst_done", 32'(done), 32'd0);
                check("mid_rst_ferr", 32'(frame_err), 32'd0);
            end
        join
        clks(2);
        rst_n = 1'b1;
        clks(c_bit);
        d0 = done_cnt;
        send(8'hC3, 1'b1);
        wait_sb(4 * c_bit);
        check("c3_done_count", 32'(done_cnt - d0), 32'd1);
        clks(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
